// File: rtl/key_tone_pkg.sv
// Shared types and pitch table for the keyboard tone generator.
// BASE_PERIOD holds lowest-octave half-periods in clocks, indexed by semitone.
package key_tone_pkg;

  localparam int BASE_W = 12;
  localparam logic [BASE_W-1:0] PERIOD_MIN = 12'd2;

  localparam logic [BASE_W-1:0] BASE_PERIOD [12] = '{
    12'd2959, 12'd2830, 12'd2675, 12'd2536, 12'd2381, 12'd2244,
    12'd2122, 12'd1992, 12'd1878, 12'd1775, 12'd1669, 12'd1587
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2
  } tone_state_e;

  // Octave of the note plus the requested shift halves the base period per step.
  function automatic logic [BASE_W-1:0] target_period(input logic [5:0] note,
                                                      input int unsigned oct);
    logic [3:0]      semi;
    logic [2:0]      note_oct;
    int unsigned     shamt;
    logic [BASE_W-1:0] p;
    semi     = 4'(note % 6'd12);
    note_oct = 3'(note / 6'd12);
    shamt    = 32'(note_oct) + oct;
    p        = (shamt >= 32'(BASE_W)) ? '0 : (BASE_PERIOD[semi] >> shamt);
    if (p < PERIOD_MIN) p = PERIOD_MIN;
    return p;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave divider: counts 0..period-1 and toggles the tone at the top.
// A shrinking period with the count already past it toggles on the next edge.
module tone_divider #(
  parameter int PERIOD_W = 32
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                clear,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tone
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clear) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (enable) begin
      if (cnt_q >= period - PERIOD_W'(1)) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/key_tone_gen.sv
// Keyboard tone generator: highest-pitch key select, gate FSM and square-wave output.
// Optional period glide is built when KEY_TONE_GEN_GLIDE_EN is defined.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no key, tone silent, divider held at zero
// ST_PLAY    | key held, gate high, period tracks the selected note
// ST_RELEASE | keys up, tone keeps running for RELEASE_CYC clocks
module key_tone_gen
  import key_tone_pkg::*;
#(
  parameter int NUM_KEYS    = 12,
  parameter int PERIOD_W    = 32,
  parameter int OCT_W       = 2,
  parameter int RELEASE_CYC = 16
`ifdef KEY_TONE_GEN_GLIDE_EN
  , parameter int GLIDE_DIV = 64
`endif
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [OCT_W-1:0]    octave,
  output logic [PERIOD_W-1:0] period,
  output logic [5:0]          note_idx,
  output logic                gate,
  output logic                tone
);

  localparam int REL_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
  localparam logic [REL_W-1:0] REL_LOAD = REL_W'(RELEASE_CYC - 1);

  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic [OCT_W-1:0]    oct_q, oct_d;
  tone_state_e         state_q, state_d;
  logic [REL_W-1:0]    rel_cnt_q, rel_cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [5:0]          note_q, note_d;

  logic                sel_any;
  logic [5:0]          sel_idx;
  logic [PERIOD_W-1:0] target;

  assign keys_d = keys;
  assign oct_d  = octave;

  // Later (higher) notes override earlier ones, so the highest pitch wins.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys_q[NUM_KEYS-1-i]) begin
        sel_any = 1'b1;
        sel_idx = 6'(i);
      end
    end
    target = PERIOD_W'(target_period(sel_idx, 32'(oct_q)));
  end

  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (!sel_any) begin
          state_d   = ST_RELEASE;
          rel_cnt_d = REL_LOAD;
        end
      end
      ST_RELEASE: begin
        // A key arriving as the release window expires keeps the note alive.
        if (sel_any)                state_d = ST_PLAY;
        else if (rel_cnt_q == '0)   state_d = ST_IDLE;
        else                        rel_cnt_d = rel_cnt_q - REL_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef KEY_TONE_GEN_GLIDE_EN
  localparam int GLIDE_W = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;
  localparam logic [GLIDE_W-1:0] GLIDE_LOAD = GLIDE_W'(GLIDE_DIV - 1);

  logic [GLIDE_W-1:0] glide_cnt_q, glide_cnt_d;

  always_comb begin
    note_d      = note_q;
    period_d    = period_q;
    glide_cnt_d = glide_cnt_q;
    if (sel_any) begin
      note_d = sel_idx;
      if (state_q == ST_IDLE) begin
        period_d    = target;
        glide_cnt_d = GLIDE_LOAD;
      end else if (period_q == target) begin
        glide_cnt_d = GLIDE_LOAD;
      end else if (glide_cnt_q == '0) begin
        period_d    = (period_q > target) ? period_q - PERIOD_W'(1)
                                          : period_q + PERIOD_W'(1);
        glide_cnt_d = GLIDE_LOAD;
      end else begin
        glide_cnt_d = glide_cnt_q - GLIDE_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) glide_cnt_q <= '0;
    else        glide_cnt_q <= glide_cnt_d;
  end
`else
  always_comb begin
    note_d   = note_q;
    period_d = period_q;
    if (sel_any) begin
      note_d   = sel_idx;
      period_d = target;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (resetn) begin
      keys_q    <= '0;
      oct_q     <= '0;
      state_q   <= ST_IDLE;
      rel_cnt_q <= '0;
      period_q  <= '0;
      note_q    <= '0;
    end else begin
      keys_q    <= keys_d;
      oct_q     <= oct_d;
      state_q   <= state_d;
      rel_cnt_q <= rel_cnt_d;
      period_q  <= period_d;
      note_q    <= note_d;
    end
  end

  // Clearing on the edge into IDLE silences the tone as soon as IDLE is entered.
  tone_divider #(
    .PERIOD_W (PERIOD_W)
  ) u_divider (
    .clock  (clock),
    .resetn (resetn),
    .clear  (state_d == ST_IDLE),
    .enable (state_q != ST_IDLE),
    .period (period_q),
    .tone   (tone)
  );

  assign period   = period_q;
  assign note_idx = note_q;
  assign gate     = (state_q == ST_PLAY);

endmodule

// File: tb/tb_key_tone_gen.sv
// Bench for key_tone_gen: a 12-key default instance and a 24-key, 4-bit-octave instance.
// Vector table for selection/period/latency, then hand sequences for tone timing, release and reset.
module tb_key_tone_gen;

  logic        clock = 1'b0;
  logic        resetn;
  logic [11:0] keys12;
  logic [1:0]  oct12;
  logic [23:0] keys24;
  logic [3:0]  oct24;
  logic [31:0] p12, p24;
  logic [5:0]  n12, n24;
  logic        g12, t12, g24, t24;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  key_tone_gen dut12 (
    .clock    (clock),
    .resetn   (resetn),
    .keys     (keys12),
    .octave   (oct12),
    .period   (p12),
    .note_idx (n12),
    .gate     (g12),
    .tone     (t12)
  );

  key_tone_gen #(.NUM_KEYS(24), .OCT_W(4)) dut24 (
    .clock    (clock),
    .resetn   (resetn),
    .keys     (keys24),
    .octave   (oct24),
    .period   (p24),
    .note_idx (n24),
    .gate     (g24),
    .tone     (t24)
  );

  typedef struct {
    logic        sel24;
    logic [23:0] keys;
    logic [3:0]  oct;
    int          exp_period;
    int          exp_note;
    int          exp_gate;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic reset_all();
    resetn = 1'b1;
    keys12 = '0;
    oct12  = '0;
    keys24 = '0;
    oct24  = '0;
    step(2);
    resetn = 1'b0;
  endtask

  initial begin
    int prev_p [2];
    int prev_n [2];
    int prev_g [2];
    int s;

    vecs[0]  = '{1'b0, 24'h000800, 4'd0, 2959,  0, 1};
    vecs[1]  = '{1'b0, 24'h000801, 4'd0, 1587, 11, 1};
    vecs[2]  = '{1'b0, 24'h000001, 4'd1,  793, 11, 1};
    vecs[3]  = '{1'b0, 24'h000040, 4'd0, 2244,  5, 1};
    vecs[4]  = '{1'b0, 24'h0000A0, 4'd0, 2122,  6, 1};
    vecs[5]  = '{1'b0, 24'h000400, 4'd2,  707,  1, 1};
    vecs[6]  = '{1'b0, 24'h000000, 4'd2,  707,  1, 0};
    vecs[7]  = '{1'b0, 24'h000100, 4'd0, 2536,  3, 1};
    vecs[8]  = '{1'b1, 24'h000001, 4'd0,  793, 23, 1};
    vecs[9]  = '{1'b1, 24'h000001, 4'd3,   99, 23, 1};
    vecs[10] = '{1'b1, 24'h000001, 4'd15,   2, 23, 1};
    vecs[11] = '{1'b1, 24'h800000, 4'd11,   2,  0, 1};
    vecs[12] = '{1'b1, 24'h800000, 4'd9,    5,  0, 1};
    vecs[13] = '{1'b1, 24'h000800, 4'd0, 1479, 12, 1};
    vecs[14] = '{1'b1, 24'h000801, 4'd0,  793, 23, 1};

    // Outputs while reset is held
    resetn = 1'b1;
    keys12 = 12'h800;
    oct12  = '0;
    keys24 = 24'h000001;
    oct24  = '0;
    step(3);
    chk("rst_period12", int'(p12), 0);
    chk("rst_note12",   int'(n12), 0);
    chk("rst_gate12",   int'(g12), 0);
    chk("rst_tone12",   int'(t12), 0);
    chk("rst_period24", int'(p24), 0);
    chk("rst_gate24",   int'(g24), 0);
    keys12 = '0;
    keys24 = '0;
    step(1);
    resetn = 1'b0;
    step(2);
    chk("idle_gate12", int'(g12), 0);
    chk("idle_tone12", int'(t12), 0);

    for (int k = 0; k < 2; k++) begin
      prev_p[k] = 0;
      prev_n[k] = 0;
      prev_g[k] = 0;
    end

    for (int i = 0; i < NV; i++) begin
      s = int'(vecs[i].sel24);
      if (vecs[i].sel24) begin
        keys24 = vecs[i].keys;
        oct24  = vecs[i].oct;
      end else begin
        keys12 = vecs[i].keys[11:0];
        oct12  = vecs[i].oct[1:0];
      end
      step(1);
      chk($sformatf("v%0d_lat1_period", i), s ? int'(p24) : int'(p12), prev_p[s]);
      chk($sformatf("v%0d_lat1_gate", i),   s ? int'(g24) : int'(g12), prev_g[s]);
      step(1);
      chk($sformatf("v%0d_period", i), s ? int'(p24) : int'(p12), vecs[i].exp_period);
      chk($sformatf("v%0d_note", i),   s ? int'(n24) : int'(n12), vecs[i].exp_note);
      chk($sformatf("v%0d_gate", i),   s ? int'(g24) : int'(g12), vecs[i].exp_gate);
      prev_p[s] = vecs[i].exp_period;
      prev_n[s] = vecs[i].exp_note;
      prev_g[s] = vecs[i].exp_gate;
    end

    // Tone half-period of 2959 clocks from a fresh start
    reset_all();
    keys12 = 12'h800;
    step(2);
    chk("tp_gate", int'(g12), 1);
    chk("tp_tone_start", int'(t12), 0);
    step(2958);
    chk("tp_tone_before1", int'(t12), 0);
    step(1);
    chk("tp_tone_edge1", int'(t12), 1);
    step(2958);
    chk("tp_tone_before2", int'(t12), 1);
    step(1);
    chk("tp_tone_edge2", int'(t12), 0);

    // Period shrinks below the running count: toggle on the next edge
    reset_all();
    keys12 = 12'h800;
    step(2);
    step(2000);
    chk("shr_tone_pre", int'(t12), 0);
    keys12 = 12'h001;
    step(2);
    chk("shr_period", int'(p12), 1587);
    chk("shr_tone_hold", int'(t12), 0);
    step(1);
    chk("shr_tone_toggle", int'(t12), 1);
    step(1586);
    chk("shr_tone_before", int'(t12), 1);
    step(1);
    chk("shr_tone_next", int'(t12), 0);

    // Release: gate drops after 2 clocks, tone runs 16 clocks, then silence
    reset_all();
    keys12 = 12'h801;
    step(2);
    step(1590);
    chk("rel_tone_high", int'(t12), 1);
    keys12 = '0;
    step(1);
    chk("rel_gate_lat1", int'(g12), 1);
    step(1);
    chk("rel_gate_low", int'(g12), 0);
    chk("rel_tone_run", int'(t12), 1);
    chk("rel_period_hold", int'(p12), 1587);
    chk("rel_note_hold", int'(n12), 11);
    step(15);
    chk("rel_tone_last", int'(t12), 1);
    step(1);
    chk("rel_tone_off", int'(t12), 0);
    chk("rel_period_idle", int'(p12), 1587);
    step(100);
    chk("rel_idle_tone", int'(t12), 0);
    chk("rel_idle_gate", int'(g12), 0);

    // Key arrives exactly as the release window expires
    reset_all();
    keys12 = 12'h801;
    step(2);
    step(1590);
    keys12 = '0;
    step(16);
    keys12 = 12'h800;
    step(1);
    chk("exp_gate_pre", int'(g12), 0);
    step(1);
    chk("exp_gate_play", int'(g12), 1);
    chk("exp_tone_phase", int'(t12), 1);
    chk("exp_period", int'(p12), 2959);
    chk("exp_note", int'(n12), 0);

    // Reset in the middle of a note
    reset_all();
    keys12 = 12'h801;
    step(2);
    step(1590);
    chk("mid_tone_high", int'(t12), 1);
    resetn = 1'b1;
    step(1);
    chk("mid_period", int'(p12), 0);
    chk("mid_note", int'(n12), 0);
    chk("mid_gate", int'(g12), 0);
    chk("mid_tone", int'(t12), 0);
    keys12 = '0;
    step(1);
    resetn = 1'b0;
    step(5);
    chk("post_gate", int'(g12), 0);
    chk("post_tone", int'(t12), 0);
    keys12 = 12'h800;
    step(1);
    chk("post_gate_lat1", int'(g12), 0);
    step(1);
    chk("post_gate_play", int'(g12), 1);
    chk("post_period", int'(p12), 2959);
    chk("post_tone_start", int'(t12), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_tone_gen.md
KEY_TONE_GEN -- requirements
Module: key_tone_gen

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 12, number of keyboard inputs (1..48).
REQ-002 SHALL have parameter PERIOD_W, default 32, half-period count width.
REQ-003 SHALL have parameter OCT_W, default 2, octave-shift input width.
REQ-004 SHALL have parameter RELEASE_CYC, default 16, clocks tone continues after key release (>=1).
REQ-005 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port resetn  input  1  synchronous, active-high reset (asserted = 1 despite the name).
REQ-007 SHALL have port keys  input  NUM_KEYS  key-down bits; MSB = note 0 (lowest pitch), bit 0 = note NUM_KEYS-1.
REQ-008 SHALL have port octave  input  OCT_W  extra upward octave shift.
REQ-009 SHALL have port period  output  PERIOD_W  active half-period in clocks.
REQ-010 SHALL have port note_idx  output  6  selected note index.
REQ-011 SHALL have port gate  output  1  high while a key is held.
REQ-012 SHALL have port tone  output  1  square-wave audio output.

Function
REQ-013 SHALL register keys and octave once (stage 1); period/note_idx/gate SHALL update on the following edge (2-clock latency from input change).
REQ-014 With multiple keys down, SHALL select the highest note index (highest pitch); no key down = no selection.
REQ-015 Target period SHALL be BASE[n mod 12] >> ((n div 12) + octave), BASE = {2959,2830,2675,2536,2381,2244,2122,1992,1878,1775,1669,1587} for n mod 12 = 0..11.
REQ-016 Target period below 2 SHALL clamp to 2; values SHALL be zero-extended to PERIOD_W.
REQ-017 FSM states IDLE, PLAY, RELEASE; IDLE->PLAY on any key; PLAY->RELEASE when no key; RELEASE->PLAY on any key; RELEASE->IDLE after RELEASE_CYC clocks.
REQ-018 gate SHALL be 1 exactly in PLAY; period and note_idx SHALL hold last values in RELEASE and IDLE.
REQ-019 Divider counter SHALL count 0..period-1 in PLAY/RELEASE; at period-1 tone SHALL toggle and counter SHALL return to 0.
REQ-020 In IDLE tone SHALL be 0 and counter 0; entering PLAY from IDLE SHALL start counter at 0 with tone 0.
REQ-021 If period decreases so counter >= new period-1, tone SHALL toggle on the next edge and counter SHALL return to 0.
REQ-022 Note change within PLAY, or RELEASE->PLAY, SHALL not reset tone phase.
REQ-023 Key pressed on the same edge RELEASE_CYC expires SHALL go to PLAY, not IDLE.

Reset
REQ-024 While resetn = 1: period = 0, note_idx = 0, gate = 0, tone = 0, counters 0, FSM = IDLE, input registers 0.
REQ-025 Reset mid-note SHALL silence tone on the same edge; first post-reset selection follows REQ-013 latency.

Configuration
REQ-026 Macro KEY_TONE_GEN_GLIDE_EN defined: parameter GLIDE_DIV (default 64); in PLAY, period SHALL step by 1 toward target every GLIDE_DIV clocks; IDLE->PLAY SHALL load target directly.
REQ-027 Macro undefined: period SHALL equal target immediately (REQ-013); no GLIDE_DIV logic present.

Structure
REQ-028 Package key_tone_pkg SHALL hold the 12-entry BASE table, state enumeration, and clamp minimum (2).
REQ-029 Sub-module tone_divider (counter + toggle, REQ-019..021) SHALL be instantiated once; selection, FSM and glide remain in the top.

Verification
REQ-030 NUM_KEYS=12, octave=0, keys=12'h800 -> period=2959, note_idx=0, gate=1 two clocks later; tone toggles every 2959 clocks.
REQ-031 keys=12'h801 -> note_idx=11, period=1587; octave=1 with keys=12'h001 -> period=793.
REQ-032 Playing, keys->0 -> gate=0 after 2 clocks; tone runs 16 more clocks then 0; period holds 1587.
REQ-033 NUM_KEYS=24, keys bit 0 only -> note_idx=23, period=793; octave=3 -> 99; period never below 2.
REQ-034 resetn=1 mid-PLAY -> all outputs 0 same edge; release -> IDLE, tone 0 until next key.
REQ-035 GLIDE_EN, GLIDE_DIV=4: 2959 held, switch to 2830 -> period decrements by 1 every 4 clocks, reaches 2830 after 516 clocks.
